// File: rtl/led_chain_defs.sv
// Shared state encodings and default sizing for the LED shift-chain transmitter.
package led_chain_defs;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;
  localparam logic [1:0] ST_LATCH    = 2'd3;

  localparam int N_LEDS_DEF  = 18;
  localparam int CLK_DIV_DEF = 2;

endpackage

// File: rtl/led_chain_tick.sv
// Half-period divider: 1-cycle tick every CLK_DIV enabled cycles, count cleared while disabled.
// Tick is combinational from the count register; no backpressure.
module led_chain_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CW   = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = en && (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_chain_shifter.sv
// Serialises one N_LEDS frame MSB-first onto a 595-style chain, then pulses rclk; frame_ready
// drops for (2*N_LEDS+1)*CLK_DIV cycles per frame and frames offered meanwhile are not taken.
module led_chain_shifter
  import led_chain_defs::*;
#(
  parameter int N_LEDS  = N_LEDS_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] frame_data,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic              ser,
  output logic              srclk,
  output logic              rclk,
  output logic              busy
);

  localparam int            BW       = $clog2(N_LEDS);
  localparam logic [BW-1:0] LAST_BIT = BW'(N_LEDS - 1);

  logic [1:0]        state;
  logic [N_LEDS-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              tick;

  led_chain_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      ser         <= 1'b0;
      srclk       <= 1'b0;
      rclk        <= 1'b0;
      busy        <= 1'b0;
      frame_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_valid && frame_ready) begin
            shreg       <= frame_data;
            bit_cnt     <= '0;
            ser         <= frame_data[N_LEDS-1];
            frame_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (tick) begin
            srclk <= 1'b1;
            state <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (tick) begin
            srclk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              rclk  <= 1'b1;
              state <= ST_LATCH;
            end else begin
              // rotate rather than shift: only the MSB side is ever put on ser
              shreg   <= {shreg[N_LEDS-2:0], shreg[N_LEDS-1]};
              bit_cnt <= bit_cnt + BW'(1);
              ser     <= shreg[N_LEDS-2];
              state   <= ST_SHIFT_LO;
            end
          end
        end
        ST_LATCH: begin
          if (tick) begin
            rclk        <= 1'b0;
            busy        <= 1'b0;
            frame_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_chain_shifter.sv
// Directed bench for led_chain_shifter at 18x2 and 4x1: bit scoreboard on srclk rises,
// closed-form timing model for srclk/rclk/ready/busy, and a 595 chain model checked at each latch.
module tb_led_chain_shifter;

  localparam int NA = 18;
  localparam int DA = 2;
  localparam int NB = 4;
  localparam int DB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NA-1:0] fd_a;
  logic          fv_a, fr_a, ser_a, srclk_a, rclk_a, busy_a;
  logic [NB-1:0] fd_b;
  logic          fv_b, fr_b, ser_b, srclk_b, rclk_b, busy_b;

  led_chain_shifter #(.N_LEDS(NA), .CLK_DIV(DA)) dut_a (
    .clk(clk), .rst(rst), .frame_data(fd_a), .frame_valid(fv_a), .frame_ready(fr_a),
    .ser(ser_a), .srclk(srclk_a), .rclk(rclk_a), .busy(busy_a)
  );

  led_chain_shifter #(.N_LEDS(NB), .CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .frame_data(fd_b), .frame_valid(fv_b), .frame_ready(fr_b),
    .ser(ser_b), .srclk(srclk_b), .rclk(rclk_b), .busy(busy_b)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          k[2];
  bit          act[2];
  logic [63:0] frm[2];
  logic [63:0] chain[2];
  logic        sidle[2];
  logic        psrclk[2], prclk[2], pser[2];
  bit          qa[$];
  bit          qb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      act[i]   = 1'b0;
      sidle[i] = 1'b0;
    end
    qa.delete();
    qb.delete();
  endtask

  // Per-cycle check of one DUT against the closed-form frame timeline.
  task automatic mon(input int id, input int n, input int d, input logic ser,
                     input logic srclk, input logic rclk, input logic fr, input logic bsy);
    int    t;
    logic  e_srclk, e_rclk;
    bit    have, b;
    string p;
    p = (id == 0) ? "a" : "b";
    t = 0;
    if (act[id]) begin
      t = cyc - k[id];
      if (t >= (2 * n + 1) * d) begin
        act[id]   = 1'b0;
        sidle[id] = frm[id][0];
      end
    end
    e_srclk = 1'b0;
    e_rclk  = 1'b0;
    if (act[id]) begin
      if (t < 2 * n * d) e_srclk = ((t / d) % 2) == 1;
      else               e_rclk  = 1'b1;
    end
    chk({p, " srclk"}, srclk, e_srclk);
    chk({p, " rclk"}, rclk, e_rclk);
    chk({p, " busy"}, bsy, act[id]);
    chk({p, " frame_ready"}, fr, !act[id]);
    if (!act[id]) chk({p, " idle ser"}, ser, sidle[id]);
    if (psrclk[id] && srclk) chk({p, " ser stable while srclk high"}, ser, pser[id]);
    if (srclk && !psrclk[id]) begin
      have = (id == 0) ? (qa.size() > 0) : (qb.size() > 0);
      chk({p, " srclk rise has pending bit"}, have, 1);
      if (have) begin
        b = (id == 0) ? qa.pop_front() : qb.pop_front();
        chk({p, " ser bit"}, ser, b);
      end
      chain[id] = {chain[id][62:0], ser};
    end
    if (rclk && !prclk[id]) begin
      chk({p, " bits left at latch"}, (id == 0) ? qa.size() : qb.size(), 0);
      chk({p, " latched leds"}, chain[id] & ((64'd1 << n) - 1), frm[id]);
    end
    psrclk[id] = srclk;
    prclk[id]  = rclk;
    pser[id]   = ser;
  endtask

  task automatic step();
    bit          acc_a, acc_b;
    logic [63:0] da, db;
    acc_a = rst && fv_a && !act[0];
    acc_b = rst && fv_b && !act[1];
    da = 64'(fd_a);
    db = 64'(fd_b);
    @(negedge clk);
    cyc++;
    if (!rst) reset_model();
    if (acc_a) begin
      k[0] = cyc; act[0] = 1'b1; frm[0] = da;
      for (int i = NA - 1; i >= 0; i--) qa.push_back(da[i]);
    end
    if (acc_b) begin
      k[1] = cyc; act[1] = 1'b1; frm[1] = db;
      for (int i = NB - 1; i >= 0; i--) qb.push_back(db[i]);
    end
    mon(0, NA, DA, ser_a, srclk_a, rclk_a, fr_a, busy_a);
    mon(1, NB, DB, ser_b, srclk_b, rclk_b, fr_b, busy_b);
  endtask

  task automatic send(input int id, input logic [63:0] v, input bit hold);
    bit got;
    got = 1'b0;
    if (id == 0) begin fd_a = v[NA-1:0]; fv_a = 1'b1; end
    else         begin fd_b = v[NB-1:0]; fv_b = 1'b1; end
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      got = act[id] && (k[id] == cyc);
    end
    if (!got) begin
      miscompares++;
      $error("FAIL accept timeout: dut %0d frame %0h never taken", id, v);
    end
    // scramble the input after accept: only the captured copy may be sent
    if (id == 0) begin if (!hold) fv_a = 1'b0; fd_a = ~fd_a; end
    else         begin if (!hold) fv_b = 1'b0; fd_b = ~fd_b; end
  endtask

  task automatic wait_idle(input int id);
    for (int i = 0; i < 400 && act[id]; i++) step();
    if (act[id]) begin
      miscompares++;
      $error("FAIL idle timeout: dut %0d still busy", id);
    end
    step();
  endtask

  initial begin
    rst  = 1'b0;
    fv_a = 1'b1;
    fd_a = 18'h2AAAA;
    fv_b = 1'b1;
    fd_b = 4'hF;
    for (int i = 0; i < 2; i++) begin
      chain[i] = '0; psrclk[i] = 1'b0; prclk[i] = 1'b0; pser[i] = 1'b0;
      k[i] = 0; frm[i] = '0;
    end
    reset_model();

    // reset held 100ns with valid asserted: nothing may be accepted
    repeat (10) step();
    rst  = 1'b1;
    fv_a = 1'b0;
    fv_b = 1'b0;
    repeat (3) step();

    // basic alternating frame
    send(0, 64'h2AAAA, 1'b0);
    wait_idle(0);

    // frame offered while busy must wait for frame_ready
    send(0, 64'h3FFFF, 1'b0);
    repeat (10) step();
    send(0, 64'h00001, 1'b0);
    wait_idle(0);

    // back-to-back with valid held high
    send(0, 64'h00F0F, 1'b1);
    send(0, 64'h3C3C3, 1'b0);
    wait_idle(0);

    // async reset just after the 9th srclk rise, then a clean frame
    send(0, 64'h1FFFF, 1'b0);
    for (int i = 0; i < 200 && cyc < k[0] + 17 * DA; i++) step();
    #2 rst = 1'b0;
    #1 reset_model();
    mon(0, NA, DA, ser_a, srclk_a, rclk_a, fr_a, busy_a);
    mon(1, NB, DB, ser_b, srclk_b, rclk_b, fr_b, busy_b);
    fv_a = 1'b1;
    fd_a = 18'h15555;
    repeat (3) step();
    rst  = 1'b1;
    fv_a = 1'b0;
    step();
    send(0, 64'h2D5A3, 1'b0);
    wait_idle(0);

    // undivided clock, 4-LED chain
    send(1, 64'h9, 1'b0);
    wait_idle(1);
    send(1, 64'h6, 1'b1);
    send(1, 64'hC, 1'b0);
    wait_idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_chain_shifter.md
Name: led_chain_shifter

Overview:
- Transmit side of the LED board's 74HC595-style serial shift-register chain.
- Accepts one parallel LED frame over a valid/ready handshake. Shifts it out MSB-first on SER/SRCLK, then pulses RCLK so all outputs update at once.
- Sits between the blink pattern generators and the board's LED pins, so patterns wider than the available I/O can be driven.

Parameters:
- N_LEDS, 18, frame width in bits (number of LEDs in the chain); legal range 2..64.
- CLK_DIV, 2, clk cycles per SRCLK/RCLK half-period; legal range >=1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- frame_data  input  N_LEDS  LED frame; bit i drives LED i.
- frame_valid  input  1  frame_data holds a frame to send.
- frame_ready  output  1  block can accept a frame this cycle.
- ser  output  1  serial data to the chain.
- srclk  output  1  shift clock to the chain.
- rclk  output  1  storage/latch clock to the chain.
- busy  output  1  a frame is in flight.

Behaviour:
- Reset (rst=0, async): state=IDLE; shreg=0; bit_cnt=0; div_cnt=0; ser=0; srclk=0; rclk=0; busy=0; frame_ready=1.
- All outputs are registered, with no combinational path from inputs.
- Transfer: frame is accepted on a rising edge where frame_valid=1 and frame_ready=1.
- frame_valid while frame_ready=0 is ignored. No buffering; the frame is not queued.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - frame_ready=1, busy=0.
  - On accept: shreg<=frame_data, bit_cnt<=0, div_cnt<=0, go to SHIFT_LO.
  - Same edge: ser<=frame_data[N_LEDS-1], frame_ready<=0, busy<=1.
- SHIFT_LO:
  - srclk=0, ser stable.
  - After CLK_DIV cycles go to SHIFT_HI with srclk<=1.
- SHIFT_HI:
  - srclk=1 for CLK_DIV cycles; the chain samples ser on the srclk rising edge.
  - On exit, if bit_cnt==N_LEDS-1: go to LATCH with srclk<=0, rclk<=1.
  - On exit otherwise: shreg<=shreg<<1, bit_cnt<=bit_cnt+1, ser<=next MSB, srclk<=0, go to SHIFT_LO.
- ser only changes on the edge where srclk falls, never while srclk=1.
- LATCH:
  - rclk=1 for CLK_DIV cycles.
  - On exit: rclk<=0, busy<=0, frame_ready<=1, go to IDLE.
- Timing, with accept at edge k:
  - srclk rising edges at k+CLK_DIV*(2j+1), for j=0..N_LEDS-1.
  - rclk rises at k+2*N_LEDS*CLK_DIV.
  - rclk falls and frame_ready returns at k+(2*N_LEDS+1)*CLK_DIV.
- Back-to-back: minimum frame period is (2*N_LEDS+1)*CLK_DIV+1 cycles, since IDLE lasts at least 1 cycle.
- Ordering: exactly N_LEDS srclk rising edges per frame, MSB first. After the latch, LED i holds frame_data[i], with frame_data[0] in the chain stage nearest the end.
- Counter widths:
  - bit_cnt is $clog2(N_LEDS) bits.
  - div_cnt is $clog2(CLK_DIV)+1 bits and counts 0..CLK_DIV-1.
  - No wrap occurs inside a frame.
- Reset mid-frame: immediate return to reset values; no RCLK pulse is emitted, so the chain's latched outputs keep the previous frame.
- frame_data changes after accept have no effect (captured copy only).

Decomposition:
- Package/header led_chain_defs: state encodings ST_IDLE=2'd0, ST_SHIFT_LO=2'd1, ST_SHIFT_HI=2'd2, ST_LATCH=2'd3; default N_LEDS and CLK_DIV constants.
- One sub-module, led_chain_tick:
  - Half-period divider with enable, parameter CLK_DIV.
  - Outputs a 1-cycle tick every CLK_DIV enabled cycles and clears when enable=0.
  - The FSM advances on tick.

Test Plan:
- Reset defaults: hold rst=0 for 100ns -> frame_ready=1, busy=0, ser=srclk=rclk=0; frame_valid=1 during reset is not accepted.
- Basic frame (N_LEDS=18, CLK_DIV=2): accept 18'h2AAAA at edge k -> ser sampled on the 18 srclk rising edges is 1,0,1,0,...,1,0 MSB-first. rclk is high for edges k+72..k+73; frame_ready=1 at k+74.
- Busy ignore: accept 18'h3FFFF, then present 18'h00001 with frame_valid=1 during shifting -> the second frame is not taken until frame_ready=1, then sends 17 zeros and a one.
- Back-to-back: hold frame_valid=1 with 18'h00F0F then 18'h3C3C3 -> two complete frames, each with exactly 18 srclk rises and one rclk pulse, 75 cycles apart.
- Reset mid-frame: assert rst=0 after the 9th srclk rise of 18'h1FFFF -> all outputs return to reset values asynchronously, no rclk pulse; a new accept then produces a full 18-bit frame.
- CLK_DIV=1, N_LEDS=4: accept 4'b1001 -> srclk toggles every cycle, ser stream 1,0,0,1, rclk high exactly 1 cycle at k+8.
